// File: rtl/esn_stream_pkg.sv
// Shared widths, FSM state type and word packing for the ESN streaming controller.
package esn_stream_pkg;

  localparam int unsigned U_W    = 16;
  localparam int unsigned EST_W  = 32;
  localparam int unsigned WORD_W = U_W + EST_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  function automatic logic [WORD_W-1:0] pack_word(input logic [U_W-1:0]   u,
                                                  input logic [EST_W-1:0] est);
    return {u, est};
  endfunction

endpackage

// File: rtl/esn_st_fifo.sv
// Synchronous FIFO with fall-through head; a push while full succeeds when a pop
// happens in the same cycle.
module esn_st_fifo #(
  parameter int unsigned WIDTH = 48,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_N,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty
);

  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign empty     = (r_count == '0);
  assign full      = (r_count == FULL_LVL);
  assign count     = r_count;
  assign dout      = r_mem[r_rd_ptr];
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);

  // Storage needs no reset; pointers alone define validity.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_N) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/esn_stream_ctrl.sv
// ESN readout streaming controller: paces the ESN core and buffers {u, est} onto Avalon-ST.
// Optional packet framing (src_sop/src_eop) is enabled by defining ESN_STREAM_SOP_EOP_EN.
module esn_stream_ctrl
  import esn_stream_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned RATE_DIV   = 1,
  parameter int unsigned PKT_LEN    = 256
) (
  input  logic              clk,
  input  logic              rst_N,
  input  logic              run_en,
  output logic              esn_ce,
  input  logic              esn_valid,
  input  logic [U_W-1:0]    esn_u,
  input  logic [EST_W-1:0]  esn_est,
  output logic [WORD_W-1:0] src_data,
  output logic              src_valid,
  input  logic              src_ready,
  output logic              busy,
  output logic [15:0]       ovf_cnt
`ifdef ESN_STREAM_SOP_EOP_EN
  ,
  output logic              src_sop,
  output logic              src_eop
`endif
);

  localparam int unsigned CW       = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] HOLD_LVL = CW'(FIFO_DEPTH - 1);
  localparam logic [15:0]   DIV_MAX  = 16'(RATE_DIV - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [15:0]       r_div;
  logic [15:0]       r_ovf;
  logic [CW-1:0]     w_count;
  logic              w_full;
  logic              w_empty;
  logic              w_pop;
  logic              w_drop;
  logic [WORD_W-1:0] w_din;
  logic [WORD_W-1:0] w_dout;

  assign w_din  = pack_word(esn_u, esn_est);
  assign w_pop  = !w_empty && src_ready;
  assign w_drop = esn_valid && w_full && !w_pop;

  esn_st_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_N (rst_N),
    .push  (esn_valid),
    .pop   (w_pop),
    .din   (w_din),
    .dout  (w_dout),
    .count (w_count),
    .full  (w_full),
    .empty (w_empty)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (run_en) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (!run_en)                w_state_nxt = ST_DRAIN;
        else if (w_count >= HOLD_LVL) w_state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        if (!run_en)               w_state_nxt = ST_DRAIN;
        else if (w_count < HOLD_LVL) w_state_nxt = ST_RUN;
      end
      ST_DRAIN: begin
        if (run_en)                      w_state_nxt = ST_RUN;
        else if (w_empty && !esn_valid)  w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_N) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Divider runs only across consecutive RUN cycles, so every RUN entry starts at phase 0.
  always_ff @(posedge clk) begin
    if (!rst_N) begin
      r_div <= '0;
    end else if (r_state == ST_RUN && w_state_nxt == ST_RUN) begin
      r_div <= (r_div == DIV_MAX) ? '0 : r_div + 16'd1;
    end else begin
      r_div <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_N) begin
      r_ovf <= '0;
    end else if (w_drop && r_ovf != '1) begin
      r_ovf <= r_ovf + 16'd1;
    end
  end

  assign esn_ce    = (r_state == ST_RUN) && (r_div == '0);
  assign busy      = (r_state != ST_IDLE);
  assign src_valid = !w_empty;
  assign src_data  = w_dout;
  assign ovf_cnt   = r_ovf;

`ifdef ESN_STREAM_SOP_EOP_EN
  localparam int unsigned PW       = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [PW-1:0] PKT_LAST = PW'(PKT_LEN - 1);

  logic [PW-1:0] r_pkt;

  always_ff @(posedge clk) begin
    if (!rst_N) begin
      r_pkt <= '0;
    end else if (r_state != ST_IDLE && w_state_nxt == ST_IDLE) begin
      r_pkt <= '0;
    end else if (w_pop) begin
      r_pkt <= (r_pkt == PKT_LAST) ? '0 : r_pkt + 1'b1;
    end
  end

  assign src_sop = src_valid && (r_pkt == '0);
  assign src_eop = src_valid && (r_pkt == PKT_LAST);
`endif

endmodule
